// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and saturating
// stall/flush performance counters for a 5-stage MIPS pipeline.
module hazard_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 2,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IDEX_MemRead,
  input  logic [4:0]           IDEX_Rt,
  input  logic [4:0]           IFID_Rs,
  input  logic [4:0]           IFID_Rt,
  input  logic                 IFID_UsesRs,
  input  logic                 IFID_UsesRt,
  input  logic                 Jump_ID,
  input  logic                 JumpReg_ID,
  input  logic                 BranchTaken_EX,
  input  logic                 CountClear,
  output logic                 PCWrite,
  output logic                 IFID_Write,
  output logic                 IFID_Flush,
  output logic                 IDEX_Bubble,
  output logic [1:0]           HazardState,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic [3:0] StallRem = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FlushRem = 4'(FLUSH_CYCLES - 1);

  state_e               state_q, state_d;
  logic [3:0]           rem_q, rem_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 load_use;
  logic                 stall_inc, flush_inc;

  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    (((IDEX_Rt == IFID_Rs) && IFID_UsesRs) ||
                     ((IDEX_Rt == IFID_Rt) && IFID_UsesRt));

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (state_q == StFlush) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      rem_d       = rem_q - 4'd1;
      if (rem_q <= 4'd1) begin
        state_d = StRun;
        rem_d   = 4'd0;
      end
    end else if (BranchTaken_EX) begin
      // A taken branch also aborts any stall in progress.
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      flush_inc   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        rem_d   = FlushRem;
      end else begin
        state_d = StRun;
        rem_d   = 4'd0;
      end
    end else if (state_q == StStall) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      stall_inc   = 1'b1;
      rem_d       = rem_q - 4'd1;
      if (rem_q <= 4'd1) begin
        state_d = StRun;
        rem_d   = 4'd0;
      end
    end else if (load_use) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      stall_inc   = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = StStall;
        rem_d   = StallRem;
      end
    end else if (Jump_ID || JumpReg_ID) begin
      IFID_Flush = 1'b1;
      flush_inc  = 1'b1;
    end
    if (!reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (CountClear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      rem_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign HazardState = state_q;
  assign StallCount  = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule
